uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Oversampling UART receiver. The asynchronous serial line is synchronized,
// each bit is divided into 16 ticks, and the bit value is the majority of the
// samples at ticks 7, 8 and 9. The frame is 1 start bit, 8 data bits (LSB
// first), an optional parity bit and 1 stop bit. A received byte sits in a
// one-entry output register with a valid/ready handshake.
//
// Parameters
//   SYNC_STAGES  number of rxd synchronizer flops (2 or 3)
//
// Ports
//   clk          block clock, rising edge
//   rstn         asynchronous active-low reset
//   rxd          serial line, idles high
//   rx_oen       pad output-enable, tied to 1 (pad is always an input)
//   baud_div     one oversample tick every baud_div+1 clk cycles
//   parity_en    1 = a parity bit follows the data bits
//   parity_odd   1 = odd parity, 0 = even parity
//   rx_data      received byte
//   rx_valid     rx_data holds a byte not yet consumed
//   rx_ready     consumer takes rx_data when rx_valid && rx_ready
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch with a good stop bit
//   overrun_err  one-cycle pulse: byte dropped because rx_data was full
//   busy         high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rxd,
    output logic        rx_oen,
    input  logic [15:0] baud_div,
    input  logic        parity_en,
    input  logic        parity_odd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rxd_s;
    logic                    rxd_prev;
    logic [15:0]             div_cnt;
    logic [3:0]              tick_cnt;
    logic [2:0]              bit_cnt;
    logic [7:0]              shift_q;
    logic                    samp7;
    logic                    samp8;
    logic [15:0]             baud_div_q;
    logic                    parity_en_q;
    logic                    parity_odd_q;
    logic                    parity_bad;

    logic                    tick;
    logic                    fall;
    logic                    majority;
    logic                    counting;

    // The pad is never driven by this block.
    assign rx_oen = 1'b1;

    // Synchronizer resets to the idle (high) line level so that reset
    // release on an idle line produces no false start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q   <= '1;
            rxd_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_prev <= rxd_s;
        end
    end

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign fall     = rxd_prev & ~rxd_s;
    assign tick     = (div_cnt == baud_div_q);
    assign counting = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

    // The third vote is the live synchronized sample at tick 9.
    assign majority = (samp7 & samp8) | (samp7 & rxd_s) | (samp8 & rxd_s);

    // Receiver FSM, baud divider, data path and output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            div_cnt      <= '0;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            samp7        <= 1'b0;
            samp8        <= 1'b0;
            baud_div_q   <= '0;
            parity_en_q  <= 1'b0;
            parity_odd_q <= 1'b0;
            parity_bad   <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            overrun_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;

            // A pop clears the register; a delivery in the same cycle
            // overrides this and keeps rx_valid set with the new byte.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (counting) begin
                if (tick) begin
                    div_cnt  <= '0;
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd7) begin
                        samp7 <= rxd_s;
                    end
                    if (tick_cnt == 4'd8) begin
                        samp8 <= rxd_s;
                    end
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state        <= START;
                        busy         <= 1'b1;
                        div_cnt      <= '0;
                        tick_cnt     <= '0;
                        baud_div_q   <= baud_div;
                        parity_en_q  <= parity_en;
                        parity_odd_q <= parity_odd;
                    end
                end

                START: begin
                    if (tick && tick_cnt == 4'd9 && majority) begin
                        // Line was back high mid start bit: treat as a glitch.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick && tick_cnt == 4'd15) begin
                        state      <= DATA;
                        bit_cnt    <= '0;
                        parity_bad <= 1'b0;
                    end
                end

                DATA: begin
                    if (tick && tick_cnt == 4'd9) begin
                        shift_q <= {majority, shift_q[7:1]};
                    end
                    if (tick && tick_cnt == 4'd15) begin
                        if (bit_cnt == 3'd7) begin
                            state <= parity_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                PARITY: begin
                    if (tick && tick_cnt == 4'd9) begin
                        parity_bad <= (majority != ((^shift_q) ^ parity_odd_q));
                    end
                    if (tick && tick_cnt == 4'd15) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (tick && tick_cnt == 4'd9) begin
                        if (!majority) begin
                            // A low stop bit usually means a break; wait
                            // for the line to recover before re-arming.
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else if (parity_bad) begin
                            parity_err <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_q;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end
                    end
                end

                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed self-checking bench for uart_rx. Frames are driven bit by bit with
// a bit period of 16*(baud_div+1) clocks; outputs are sampled 1 time unit
// after the rising edge, and error pulses are counted on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rxd;
    logic        rx_oen;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        parity_err;
    logic        overrun_err;
    logic        busy;

    int n_checks    = 0;
    int n_fail      = 0;
    int frame_cnt   = 0;
    int parity_cnt  = 0;
    int overrun_cnt = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .rx_oen     (rx_oen),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    // Every cycle an error output is high adds one, so a count of exactly
    // one also proves the pulse lasted a single cycle.
    always @(negedge clk) begin
        if (frame_err)   frame_cnt   <= frame_cnt + 1;
        if (parity_err)  parity_cnt  <= parity_cnt + 1;
        if (overrun_err) overrun_cnt <= overrun_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveBit(input logic v, input int n);
        rxd = v;
        repeat (16 * n) @(posedge clk);
        #1;
    endtask

    // Drives start, data and optional parity, then leaves the line high as
    // the stop bit and returns at the start of the stop bit.
    task automatic applyStimulus(input logic [7:0] data, input logic with_par,
                                 input logic par_bit, input int n);
        @(posedge clk);
        #1;
        driveBit(1'b0, n);
        for (int i = 0; i < 8; i++) begin
            driveBit(data[i], n);
        end
        if (with_par) begin
            driveBit(par_bit, n);
        end
        rxd = 1'b1;
    endtask

    task automatic finishFrame(input int n);
        repeat (16 * n) @(posedge clk);
        #1;
    endtask

    task automatic popByte();
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        rxd        = 1'b1;
        rx_ready   = 1'b0;
        baud_div   = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_errors", {frame_err, parity_err, overrun_err}, 0);
        checkOutput("reset_rx_oen", rx_oen, 1);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 0xA5, baud_div 0, no parity, with exact latency of rx_valid
        applyStimulus(8'hA5, 1'b0, 1'b0, 1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("a5_latency_early", rx_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("a5_latency_valid", rx_valid, 1);
        checkOutput("a5_data", rx_data, 8'hA5);
        finishFrame(1);
        checkOutput("a5_busy_after", busy, 0);
        checkOutput("a5_no_errors", frame_cnt + parity_cnt + overrun_cnt, 0);
        popByte();
        checkOutput("a5_pop_clears", rx_valid, 0);

        // Odd parity on 0x03: parity bit must be 1
        baud_div   = 16'd1;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        applyStimulus(8'h03, 1'b1, 1'b0, 2);
        finishFrame(2);
        checkOutput("par_bad_count", parity_cnt, 1);
        checkOutput("par_bad_no_valid", rx_valid, 0);
        checkOutput("par_bad_no_frame", frame_cnt, 0);
        applyStimulus(8'h03, 1'b1, 1'b1, 2);
        finishFrame(2);
        checkOutput("par_good_valid", rx_valid, 1);
        checkOutput("par_good_data", rx_data, 8'h03);
        checkOutput("par_good_count", parity_cnt, 1);
        popByte();

        // Even parity on 0x07: parity bit must be 1
        parity_odd = 1'b0;
        applyStimulus(8'h07, 1'b1, 1'b1, 2);
        finishFrame(2);
        checkOutput("even_valid", rx_valid, 1);
        checkOutput("even_data", rx_data, 8'h07);
        checkOutput("even_count", parity_cnt, 1);
        popByte();

        // Line held low for 20 bit times
        parity_en = 1'b0;
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (20 * 16 * 2) @(posedge clk);
        #1;
        checkOutput("break_frame_count", frame_cnt, 1);
        checkOutput("break_no_valid", rx_valid, 0);
        checkOutput("break_busy_held", busy, 1);
        rxd = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("break_idle_after_high", busy, 0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 2);
        finishFrame(2);
        checkOutput("post_break_valid", rx_valid, 1);
        checkOutput("post_break_data", rx_data, 8'h5A);
        checkOutput("post_break_frame_count", frame_cnt, 1);
        popByte();

        // Overrun: rx_ready held low across two deliveries
        baud_div = 16'd0;
        applyStimulus(8'h11, 1'b0, 1'b0, 1);
        finishFrame(1);
        checkOutput("ovr_first_data", rx_data, 8'h11);
        applyStimulus(8'h22, 1'b0, 1'b0, 1);
        finishFrame(1);
        checkOutput("ovr_count", overrun_cnt, 1);
        checkOutput("ovr_data_kept", rx_data, 8'h11);
        checkOutput("ovr_valid_kept", rx_valid, 1);

        // rx_ready exactly in the delivery cycle: pop and push together
        applyStimulus(8'h22, 1'b0, 1'b0, 1);
        repeat (12) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        checkOutput("popush_valid", rx_valid, 1);
        checkOutput("popush_data", rx_data, 8'h22);
        finishFrame(1);
        checkOutput("popush_no_overrun", overrun_cnt, 1);
        popByte();
        checkOutput("popush_pop_clears", rx_valid, 0);

        // 6-tick low glitch at baud_div 3
        baud_div = 16'd3;
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        rxd = 1'b1;
        checkOutput("glitch_busy_seen", busy, 1);
        repeat (64) @(posedge clk);
        #1;
        checkOutput("glitch_busy_cleared", busy, 0);
        checkOutput("glitch_no_errors", frame_cnt + parity_cnt + overrun_cnt, 3);
        checkOutput("glitch_no_valid", rx_valid, 0);

        // Reset during data bit 4 of 0xFF
        baud_div = 16'd1;
        @(posedge clk);
        #1;
        driveBit(1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            driveBit(1'b1, 2);
        end
        rxd = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        checkOutput("mid_reset_busy_before", busy, 1);
        rstn = 1'b0;
        #2;
        checkOutput("mid_reset_rx_data", rx_data, 0);
        checkOutput("mid_reset_rx_valid", rx_valid, 0);
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_errors", {frame_err, parity_err, overrun_err}, 0);
        checkOutput("mid_reset_rx_oen", rx_oen, 1);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5 * 16 * 2) @(posedge clk);
        #1;
        checkOutput("post_reset_idle", busy, 0);
        applyStimulus(8'h81, 1'b0, 1'b0, 2);
        finishFrame(2);
        checkOutput("post_reset_valid", rx_valid, 1);
        checkOutput("post_reset_data", rx_data, 8'h81);
        checkOutput("post_reset_no_errors", frame_cnt + parity_cnt + overrun_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
